// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART bit timing, frame constants and FSM state encodings
package uart_pkg;
    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = FRAME_BITS - 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4
    } uart_state_t;

    function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered full/empty flags
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] enq_data,
    input  logic             enq_valid,
    output logic             enq_ready,
    output logic [WIDTH-1:0] deq_data,
    output logic             deq_valid,
    input  logic             deq_ready
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic [PW:0]      count_d;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    // Flags come from registered occupancy, so a pop never frees a slot in the same cycle.
    assign push      = enq_valid && !full;
    assign pop       = deq_ready && !empty;
    assign enq_ready = !full;
    assign deq_valid = !empty;
    assign deq_data  = mem[rd_ptr];

    always_comb begin
        count_d = count;
        if (push && !pop) begin
            count_d = count + 1'b1;
        end else if (pop && !push) begin
            count_d = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_d;
            full  <= (count_d == (PW+1)'(DEPTH));
            empty <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= enq_data;
        end
    end
endmodule

// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - buffered 8N1 UART transmitter, FIFO-fed, LSB first
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic       serial_out,
    output logic       busy
);
    localparam int SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
    localparam int CW = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(SYMBOL_EDGE_TIME - 1);
    localparam logic [3:0]    BIT_LAST = 4'(DATA_BITS - 1);

    uart_state_t   state;
    uart_state_t   state_d;
    logic [CW-1:0] cyc_cnt;
    logic [CW-1:0] cyc_cnt_d;
    logic [3:0]    bit_cnt;
    logic [3:0]    bit_cnt_d;
    logic [7:0]    shift;
    logic [7:0]    shift_d;
    logic          serial_q;
    logic          serial_d;
    logic          busy_q;
    logic          busy_d;
    logic [7:0]    fifo_data;
    logic          fifo_valid;
    logic          fifo_pop;
    logic          bit_end;

    sync_fifo #(
        .WIDTH(8),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .enq_data  (data_in),
        .enq_valid (data_in_valid),
        .enq_ready (data_in_ready),
        .deq_data  (fifo_data),
        .deq_valid (fifo_valid),
        .deq_ready (fifo_pop)
    );

    assign bit_end    = (cyc_cnt == CYC_LAST);
    assign serial_out = serial_q;
    assign busy       = busy_q;

    always_comb begin
        state_d   = state;
        cyc_cnt_d = cyc_cnt;
        bit_cnt_d = bit_cnt;
        shift_d   = shift;
        fifo_pop  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fifo_valid) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                fifo_pop  = 1'b1;
                shift_d   = fifo_data;
                cyc_cnt_d = '0;
                bit_cnt_d = '0;
                state_d   = ST_START;
            end
            ST_START: begin
                cyc_cnt_d = bit_end ? '0 : cyc_cnt + 1'b1;
                if (bit_end) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                cyc_cnt_d = bit_end ? '0 : cyc_cnt + 1'b1;
                if (bit_end) begin
                    shift_d = {1'b0, shift[7:1]};
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                cyc_cnt_d = bit_end ? '0 : cyc_cnt + 1'b1;
                if (bit_end) begin
                    state_d = fifo_valid ? ST_LOAD : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The line register is loaded from the next state so it changes on the same edge as the FSM.
        case (state_d)
            ST_START: serial_d = 1'b0;
            ST_DATA:  serial_d = shift_d[0];
            default:  serial_d = 1'b1;
        endcase

        busy_d = (state_d != ST_IDLE) || fifo_valid || (data_in_valid && data_in_ready);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            cyc_cnt  <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            serial_q <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_d;
            cyc_cnt  <= cyc_cnt_d;
            bit_cnt  <= bit_cnt_d;
            shift    <= shift_d;
            serial_q <= serial_d;
            busy_q   <= busy_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb/tb_uart_tx_buffered.sv - self-checking bench for uart_tx_buffered against a queue/timeline model
module tb_uart_tx_buffered;
    localparam int SET   = 10;
    localparam int DEPTH = 8;
    localparam int FRAME = 10 * SET;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_in_valid = 1'b0;
    logic       data_in_ready;
    logic       serial_out;
    logic       busy;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    // Model: queue contents plus phase (0 idle, 1 load, 2 frame) and time into the frame.
    logic [7:0] m_q[$];
    logic [7:0] m_byte;
    int         m_phase = 0;
    int         m_t = 0;
    bit         m_acc;
    bit         m_ne;
    bit         m_rst_pulse = 1'b0;
    bit         chk_en = 1'b0;

    logic [7:0] rx_log[$];
    int         rx_starts[$];
    logic [7:0] sent[$];
    bit         rx_active = 1'b0;
    bit         rx_prev = 1'b1;
    int         rx_cnt = 0;
    logic [7:0] rx_byte;
    int         last_acc = 0;
    int         e;
    logic [9:0] got_bits;
    logic [9:0] exp_bits;

    uart_tx_buffered #(
        .CLOCK_FREQ(1_000),
        .BAUD_RATE (100),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready),
        .serial_out   (serial_out),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int exp_line();
        int b;
        if (m_phase != 2) return 1;
        b = m_t / SET;
        if (b == 0) return 0;
        if (b == 9) return 1;
        return int'(m_byte[b-1]);
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
        m_rst_pulse = reset;
        if (reset) begin
            m_q.delete();
            m_phase = 0;
            m_t = 0;
            chk_en = 1'b1;
        end else begin
            m_acc = data_in_valid && (m_q.size() < DEPTH);
            m_ne  = (m_q.size() != 0);
            case (m_phase)
                0: if (m_ne) m_phase = 1;
                1: begin
                    m_byte = m_q.pop_front();
                    m_phase = 2;
                    m_t = 0;
                end
                default: begin
                    m_t++;
                    if (m_t == FRAME) m_phase = m_ne ? 1 : 0;
                end
            endcase
            if (m_acc) m_q.push_back(data_in);
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("serial_out", serial_out, exp_line());
            check("data_in_ready", data_in_ready, int'(m_q.size() < DEPTH));
            check("busy", busy, int'((m_phase != 0) || (m_q.size() != 0)));
        end
    end

    // Independent line decoder sampling at mid-bit.
    initial forever begin
        @(negedge clk);
        if (m_rst_pulse) begin
            rx_active = 1'b0;
            rx_prev = 1'b1;
        end else begin
            if (rx_active) begin
                rx_cnt++;
                if (rx_cnt % SET == SET / 2) begin
                    if (rx_cnt / SET >= 1 && rx_cnt / SET <= 8) rx_byte[rx_cnt / SET - 1] = serial_out;
                    if (rx_cnt / SET == 9) begin
                        rx_log.push_back(rx_byte);
                        rx_active = 1'b0;
                    end
                end
            end else if (rx_prev && !serial_out) begin
                rx_active = 1'b1;
                rx_cnt = 0;
                rx_starts.push_back(cyc);
            end
            rx_prev = serial_out;
        end
    end

    task automatic push_byte(input logic [7:0] b);
        int n = 0;
        data_in = b;
        data_in_valid = 1'b1;
        while (!data_in_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) check("push_timeout", n, 0);
        @(negedge clk);
        last_acc = cyc;
        sent.push_back(b);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        data_in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        rx_log.delete();
        rx_starts.delete();
        sent.delete();
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || rx_active) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) check("idle_timeout", n, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_log(input string name);
        check({name, "_count"}, rx_log.size(), sent.size());
        foreach (sent[i]) begin
            if (i < rx_log.size()) check({name, "_byte"}, int'(rx_log[i]), int'(sent[i]));
        end
    endtask

    initial begin
        do_reset();
        check("rst_serial", serial_out, 1);
        check("rst_ready", data_in_ready, 1);
        check("rst_busy", busy, 0);

        push_byte(8'h41);
        data_in_valid = 1'b0;
        e = 0;
        while (serial_out && e < 20) begin
            @(negedge clk);
            e++;
        end
        check("start_latency", e, 2);
        repeat (SET / 2) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            got_bits[k] = serial_out;
            if (k < 9) repeat (SET) @(negedge clk);
        end
        exp_bits = 10'b1010000010;
        check("single_bits", int'(got_bits), int'(exp_bits));
        repeat (4) @(negedge clk);
        check("busy_last_cycle", busy, 1);
        @(negedge clk);
        check("busy_cleared", busy, 0);
        wait_idle();
        check_log("single");

        do_reset();
        for (int i = 0; i < 4; i++) push_byte(8'(8'h41 + i));
        data_in_valid = 1'b0;
        wait_idle();
        check_log("burst");
        for (int i = 1; i < rx_starts.size(); i++)
            check("burst_spacing", rx_starts[i] - rx_starts[i-1], FRAME + 1);

        do_reset();
        push_byte(8'hA0);
        data_in_valid = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 8; i++) push_byte(8'(8'hB0 + i));
        check("full_ready", data_in_ready, 0);
        data_in = 8'hEE;
        data_in_valid = 1'b1;
        @(negedge clk);
        data_in_valid = 1'b0;
        push_byte(8'hB8);
        data_in_valid = 1'b0;
        if (rx_starts.size() > 0) check("held_accept", last_acc - rx_starts[0], FRAME + 2);
        else check("held_accept_frame", 0, 1);
        wait_idle();
        check_log("full");

        do_reset();
        push_byte(8'h5A);
        push_byte(8'h01);
        push_byte(8'h02);
        push_byte(8'h03);
        data_in_valid = 1'b0;
        e = 0;
        while ((rx_starts.size() == 0 || cyc - rx_starts[0] < 4 * SET + SET / 2) && e < 500) begin
            @(negedge clk);
            e++;
        end
        if (e >= 500) check("mid_timeout", e, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_serial", serial_out, 1);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_ready", data_in_ready, 1);
        repeat (300) @(negedge clk);
        check("rst_mid_frames", rx_starts.size(), 1);
        check("rst_mid_bytes", rx_log.size(), 0);

        do_reset();
        for (int i = 0; i < 30; i++) begin
            push_byte(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 3) == 0) begin
                data_in_valid = 1'b0;
                repeat ($urandom_range(1, 250)) @(negedge clk);
            end
        end
        data_in_valid = 1'b0;
        wait_idle();
        check_log("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: got cycle %0d expected completion", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

- Buffered 8N1 UART transmitter on the FPGA side of the host serial link. This is the block that drives `FPGA_SERIAL_TX`.
- Bytes arrive on a ready/valid interface, queue in a small synchronous FIFO, and are serialized LSB-first at `BAUD_RATE`.
- Queued bytes go out back-to-back, so an echo path can absorb bursts while the line is busy.

## Interface
Parameters:
- `CLOCK_FREQ`, default 125_000_000: system clock frequency in Hz.
- `BAUD_RATE`, default 115_200: line rate in bits/s.
- `FIFO_DEPTH`, default 8: entries in the queue. Must be a power of two, ≥2.

Ports (one clock; reset is synchronous and active-high):
- `clk`, input, 1: system clock. All logic is on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `data_in`, input, 8: byte to transmit.
- `data_in_valid`, input, 1: `data_in` is valid this cycle.
- `data_in_ready`, output, 1: the FIFO can accept a byte this cycle.
- `serial_out`, output, 1: UART line. Idle level is high.
- `busy`, output, 1: a frame is in progress or the FIFO is non-empty.

## Operation
- **Bit time:** `SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE`, integer division. This is 1085 cycles at the defaults. Every bit is held for exactly `SYMBOL_EDGE_TIME` cycles.
- **Frame:** 10 bits in this order: start bit 0, data[0]…data[7], stop bit 1.
- **Accept:** a byte is accepted on a rising edge where `data_in_valid && data_in_ready`.
  - `data_in_ready = !full`, derived from registered occupancy.
  - A byte presented while `data_in_ready` is low is ignored, not latched.
  - The source must hold `data_in` until it is accepted.
- **FSM states:** IDLE, LOAD, START, DATA, STOP.
  - IDLE: `serial_out` = 1. Go to LOAD when the FIFO is non-empty.
  - LOAD: pop the FIFO head into the 8-bit shift register. Go to START.
  - START: drive 0 for one bit time. Go to DATA.
  - DATA: drive `shift[0]`; shift right every bit time. After 8 bits go to STOP.
  - STOP: drive 1 for one bit time. At the end, go to LOAD if the FIFO is non-empty, otherwise to IDLE.
- **Counters:** `bit_cnt` is 4 bits. `cyc_cnt` is `$clog2(SYMBOL_EDGE_TIME)` bits and wraps to 0 at `SYMBOL_EDGE_TIME-1`.
- **FIFO arithmetic:** pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally. The count is `$clog2(FIFO_DEPTH)+1` bits.
- **FIFO full:** push is blocked. A pop in the same cycle does not make `data_in_ready` high that cycle; it goes high the next cycle.
- **FIFO empty:** there is no bypass. A push into an empty FIFO is popped no earlier than the next cycle.
- **Simultaneous push and pop (not full, not empty):** both take effect and the count is unchanged.
- **Reset mid-operation:** the current frame is truncated and the FIFO is flushed.

## Timing
Reset values, taking effect on the edge where `reset` is sampled high:
- `serial_out` = 1, `data_in_ready` = 1, `busy` = 0.
- FSM = IDLE, FIFO count = 0, pointers = 0, counters = 0.

Latency and throughput:
- Byte accepted at edge t with FSM idle and FIFO empty: LOAD at t+1, and `serial_out` falls at edge t+2.
- `serial_out` is registered, so there are no combinational paths from inputs to `serial_out`.
- One frame takes exactly `10*SYMBOL_EDGE_TIME` cycles.
- Back-to-back frames have a 1-cycle gap, the LOAD state, between the end of the stop bit and the next start bit. The stop bit is therefore `SYMBOL_EDGE_TIME+1` cycles when another byte follows.
- Sustained throughput is one byte per `10*SYMBOL_EDGE_TIME+1` cycles.

`busy`:
- Registered.
- High from the cycle after the first accept until the cycle after the final stop bit ends with the FIFO empty.

## Structure
- Shared `uart_pkg`/include: the `SYMBOL_EDGE_TIME` computation, `FRAME_BITS = 10`, and the FSM state encodings. The receiver uses the same definitions.
- Sub-module `sync_fifo` (`WIDTH`, `DEPTH`): single-clock, with `enq_valid`/`enq_ready`/`deq_valid`/`deq_ready`, registered full/empty, and synchronous active-high reset.
- Top level: FSM, bit and cycle counters, shift register, and output register.

## Test plan
Use `CLOCK_FREQ=1_000`, `BAUD_RATE=100` (10 cycles/bit) unless noted.
- **Single byte:** push 0x41 once → `serial_out` falls 2 cycles after accept. Bits sampled mid-bit read 0,1,0,0,0,0,0,1,0,1. `busy` clears after 100 cycles of frame.
- **Burst:** push 0x41, 0x42, 0x43, 0x44 on consecutive cycles → four frames, payloads in order, 101 cycles between falling start edges.
- **Full:** push 9 bytes with the FSM still in its first frame → `data_in_ready` low after the 8th accept is queued. The 9th byte is held and accepted the cycle after the FIFO pops.
- **Reset mid-frame:** assert `reset` during data bit 3 of 0x5A with 3 bytes queued → `serial_out`=1 the next cycle, `busy`=0, and no further frames appear.
- **Ready low:** valid pulsed while `data_in_ready`=0 → the byte never appears on the line.
- **Defaults:** 125 MHz / 115200 → bit period 1085 cycles. Echo bench of 60 characters 0x41…0x7C completes with no mismatches.
